rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one output channel among 2**POWER_N requesters.
- Selects one requester and computes the N:1 select index, then routes that requester's data, valid and last to the shared output.
- Holds the grant until the end of a packet or a beat-limit timeout, then rotates priority.
- Sits in front of the parameterised N:1 multiplexer datapath and drives its select input.

Parameters:
- POWER_N, 2, log2 of requester count; N = 2**POWER_N; must be >= 1.
- DATA_W, 8, data width per requester.
- MAX_BEATS, 16, maximum beats per grant before forced release; must be >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester valid; bit k = requester k has a beat.
- data_in  input  N*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
- last_in  input  N  per-requester end-of-packet flag.
- ack  output  N  per-requester ready; bit k high when requester k's beat is accepted this cycle.
- out_valid  output  1  shared channel valid.
- out_data  output  DATA_W  shared channel data.
- out_last  output  1  shared channel end-of-packet.
- out_ready  input  1  downstream ready.
- sel  output  POWER_N  registered select index of the current owner (mux select).
- grant  output  N  registered one-hot owner; all zero when idle.
- busy  output  1  high in LOCKED state.

Behaviour:
- States: IDLE, LOCKED. Reset: state=IDLE, sel=0, grant=0, busy=0, ptr=0, beat_cnt=0. out_valid, out_last and ack are combinationally 0 in IDLE.
- ptr (POWER_N bits) is the highest-priority requester index for the next arbitration.
- IDLE:
  - If req != 0, choose the first k with req[k]=1, searching k = ptr, ptr+1, ... wrapping mod N.
  - Next edge: sel=k, grant=1<<k, beat_cnt=0, state=LOCKED.
  - If req == 0, stay in IDLE.
  - Arbitration latency is 1 cycle: the first beat cannot transfer in the cycle req rises.
- LOCKED:
  - out_valid = req[sel]; out_data = data_in slice [sel]; out_last = last_in[sel].
  - ack[sel] = out_ready; all other ack bits are 0.
  - A transfer occurs when out_valid && out_ready. Only the owner can ever be acked.
  - On a transfer, beat_cnt increments.
  - Release occurs on a transfer with out_last=1, or on a transfer where beat_cnt == MAX_BEATS-1 (timeout).
  - On release, next edge: state=IDLE, grant=0, busy=0, ptr = sel+1 with wrap (N-1 -> 0); sel holds its value.
  - The released requester therefore has lowest priority at the next arbitration.
- Owner drops req mid-packet: stay LOCKED, out_valid=0, beat_cnt frozen, no timeout while stalled.
- out_ready low: data, last and valid are held from the requester side; the arbiter state is unchanged.
- Non-owner req changes while LOCKED are ignored.
- Single-beat packet (last on first beat) releases after one transfer.
- Minimum cycle per packet is arbitration + beats; IDLE lasts exactly one cycle between back-to-back packets when any req is pending.
- Asynchronous reset at any time, including mid-packet: immediately return to reset values. Partial packets are abandoned and no ack is asserted.
- Width rules: beat_cnt is $clog2(MAX_BEATS+1) bits. ptr and sel wrap naturally modulo N because N is a power of 2.

Test Plan:
- Reset/idle (POWER_N=2): rst_n low with req=4'b1111 -> grant=0, sel=0, busy=0, out_valid=0, ack=0. Release reset, next edge -> sel=0, grant=4'b0001.
- Rotation: all four requesters send 1-beat packets continuously, out_ready=1 -> grant order 0,1,2,3,0. Each output beat carries the owner's data_in slice. ack is one-hot on the owner.
- Packet lock: req[2] sends a 3-beat packet (last on beat 3) while req[0] is also asserted -> sel stays 2 for all 3 beats. req[0] is granted only after release, because ptr=3 and the search wraps to 0.
- Backpressure: owner 1, out_ready low for 4 cycles mid-packet -> out_valid=1, ack=0, beat_cnt unchanged. Resumes when ready returns with no beat lost or duplicated.
- Timeout: MAX_BEATS=4, requester 3 streams with last_in=0 -> forced release after beat 4. ptr wraps to 0 and busy drops for one cycle.
- Reset mid-packet: assert rst_n low during beat 2 of a 5-beat packet -> all outputs 0 at once. After release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// Shared-channel bundle between the requesters and the round-robin arbiter.
// The master side drives requests and downstream ready; the slave (arbiter) drives acks and output.
interface rr_mux_arbiter_if #(
   parameter int unsigned POWER_N = 2,
   parameter int unsigned DATA_W  = 8
);
   localparam int unsigned NumReq = 2 ** POWER_N;

   logic [NumReq-1:0]        req;
   logic [NumReq*DATA_W-1:0] data_in;
   logic [NumReq-1:0]        last_in;
   logic [NumReq-1:0]        ack;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_last;
   logic                     out_ready;

   modport master (
      output req, data_in, last_in, out_ready,
      input  ack, out_valid, out_data, out_last
   );

   modport slave (
      input  req, data_in, last_in, out_ready,
      output ack, out_valid, out_data, out_last
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Packet-locked round-robin arbiter: grants one of 2**POWER_N requesters, routes its beats to the
// shared channel until end-of-packet or a beat-limit timeout, then rotates priority past it.
module rr_mux_arbiter #(
   parameter int unsigned POWER_N   = 2,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   rr_mux_arbiter_if.slave         bus,
   output logic [POWER_N-1:0]      sel,
   output logic [2**POWER_N-1:0]   grant,
   output logic                    busy
);
   localparam int unsigned NumReq = 2 ** POWER_N;
   localparam int unsigned CntW   = $clog2(MAX_BEATS + 1);

   typedef enum logic {StIdle, StLocked} state_e;

   state_e              state_q, state_d;
   logic [POWER_N-1:0]  sel_q, sel_d;
   logic [NumReq-1:0]   grant_q, grant_d;
   logic [POWER_N-1:0]  ptr_q, ptr_d;
   logic [CntW-1:0]     cnt_q, cnt_d;

   logic                found;
   logic [POWER_N-1:0]  pick;
   logic [POWER_N-1:0]  idx;
   logic                own_valid;
   logic                own_last;
   logic                xfer;
   logic                release_now;

   // First pending requester at or after ptr, wrapping modulo NumReq.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx = ptr_q + POWER_N'(i);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Output routing; everything is forced low while idle.
   always_comb begin
      own_valid     = 1'b0;
      own_last      = 1'b0;
      bus.out_data  = '0;
      bus.ack       = '0;
      if (state_q == StLocked) begin
         own_valid         = bus.req[sel_q];
         own_last          = bus.last_in[sel_q];
         bus.out_data      = bus.data_in[sel_q*DATA_W +: DATA_W];
         bus.ack[sel_q]    = bus.out_ready;
      end
      bus.out_valid = own_valid;
      bus.out_last  = own_last;
   end

   assign xfer        = own_valid && bus.out_ready;
   assign release_now = xfer && (own_last || (cnt_q == CntW'(MAX_BEATS - 1)));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StLocked;
               sel_d   = pick;
               grant_d = NumReq'(1) << pick;
               cnt_d   = '0;
            end
         end
         StLocked: begin
            if (release_now) begin
               // Sel keeps the last owner; only ptr moves past it.
               state_d = StIdle;
               grant_d = '0;
               ptr_d   = sel_q + POWER_N'(1);
               cnt_d   = '0;
            end else if (xfer) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sel   = sel_q;
   assign grant = grant_q;
   assign busy  = (state_q == StLocked);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with four requesters and a four-beat grant limit.
module tb_rr_mux_arbiter;
   logic       clk;
   logic       rst_n;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy;
   int         checks;
   int         errors;

   rr_mux_arbiter_if #(.POWER_N(2), .DATA_W(8)) bus ();

   rr_mux_arbiter #(.POWER_N(2), .DATA_W(8), .MAX_BEATS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .sel   (sel),
      .grant (grant),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_data(input int k, input logic [7:0] v);
      bus.data_in[k*8 +: 8] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      bus.last_in = '0;
      bus.out_ready = 1'b0;
      bus.data_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = 4'b1111;
      bus.last_in = '0;
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if ({grant, sel, busy, bus.out_valid, bus.ack} !== 12'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h",
                  {grant, sel, busy, bus.out_valid, bus.ack}, 12'h0);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({grant, busy} !== 5'h0) begin
         errors++;
         $display("FAIL reset_held: got %h expected %h", {grant, busy}, 5'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({sel, grant, busy, bus.out_valid, bus.ack} !== {2'd0, 4'b0001, 1'b1, 1'b1, 4'b0000}) begin
         errors++;
         $display("FAIL reset_first_grant: got %h expected %h",
                  {sel, grant, busy, bus.out_valid, bus.ack},
                  {2'd0, 4'b0001, 1'b1, 1'b1, 4'b0000});
      end
   endtask

   task automatic test_rotation();
      logic [1:0] es;
      logic [3:0] eg;
      do_reset();
      for (int k = 0; k < 4; k++) set_data(k, 8'hA0 + 8'(k));
      bus.req = 4'b1111;
      bus.last_in = 4'b1111;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         es = 2'(i % 4);
         eg = 4'b0001 << es;
         @(negedge clk);
         #1;
         checks++;
         if ({busy, sel, grant, bus.ack, bus.out_valid, bus.out_last, bus.out_data} !==
             {1'b1, es, eg, eg, 1'b1, 1'b1, 8'hA0 + 8'(es)}) begin
            errors++;
            $display("FAIL rotation_owner[%0d]: got %h expected %h", i,
                     {busy, sel, grant, bus.ack, bus.out_valid, bus.out_last, bus.out_data},
                     {1'b1, es, eg, eg, 1'b1, 1'b1, 8'hA0 + 8'(es)});
         end
         @(negedge clk);
         #1;
         checks++;
         if ({busy, bus.out_valid, bus.ack, grant} !== 10'h0) begin
            errors++;
            $display("FAIL rotation_idle[%0d]: got %h expected %h", i,
                     {busy, bus.out_valid, bus.ack, grant}, 10'h0);
         end
      end
   endtask

   task automatic test_packet_lock();
      do_reset();
      set_data(0, 8'h05);
      set_data(2, 8'h21);
      bus.req = 4'b0100;
      bus.last_in = 4'b0000;
      bus.out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         set_data(2, 8'h21 + 8'(b));
         bus.req = 4'b0101;
         bus.last_in = (b == 2) ? 4'b0100 : 4'b0000;
         #1;
         checks++;
         if ({sel, grant, bus.ack, bus.out_last, bus.out_data} !==
             {2'd2, 4'b0100, 4'b0100, (b == 2), 8'h21 + 8'(b)}) begin
            errors++;
            $display("FAIL lock_beat[%0d]: got %h expected %h", b,
                     {sel, grant, bus.ack, bus.out_last, bus.out_data},
                     {2'd2, 4'b0100, 4'b0100, (b == 2), 8'h21 + 8'(b)});
         end
      end
      @(negedge clk);
      bus.req = 4'b0001;
      bus.last_in = 4'b0000;
      #1;
      checks++;
      if ({busy, grant, sel} !== {1'b0, 4'b0000, 2'd2}) begin
         errors++;
         $display("FAIL lock_release: got %h expected %h", {busy, grant, sel},
                  {1'b0, 4'b0000, 2'd2});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({grant, sel, bus.out_data} !== {4'b0001, 2'd0, 8'h05}) begin
         errors++;
         $display("FAIL lock_wrap_grant: got %h expected %h", {grant, sel, bus.out_data},
                  {4'b0001, 2'd0, 8'h05});
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      set_data(1, 8'h11);
      bus.req = 4'b0010;
      bus.last_in = 4'b0000;
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({sel, bus.ack, bus.out_data} !== {2'd1, 4'b0010, 8'h11}) begin
         errors++;
         $display("FAIL bp_first_beat: got %h expected %h", {sel, bus.ack, bus.out_data},
                  {2'd1, 4'b0010, 8'h11});
      end
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         set_data(1, 8'h12);
         bus.out_ready = 1'b0;
         #1;
         checks++;
         if ({busy, bus.out_valid, bus.ack, bus.out_data} !== {1'b1, 1'b1, 4'b0000, 8'h12}) begin
            errors++;
            $display("FAIL bp_stall[%0d]: got %h expected %h", s,
                     {busy, bus.out_valid, bus.ack, bus.out_data},
                     {1'b1, 1'b1, 4'b0000, 8'h12});
         end
      end
      // Beats 2..4 follow; the fourth transfer hits the limit only if the stall left the count alone.
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         set_data(1, 8'h12 + 8'(b));
         bus.out_ready = 1'b1;
         #1;
         checks++;
         if ({busy, bus.ack, bus.out_data} !== {1'b1, 4'b0010, 8'h12 + 8'(b)}) begin
            errors++;
            $display("FAIL bp_resume[%0d]: got %h expected %h", b,
                     {busy, bus.ack, bus.out_data}, {1'b1, 4'b0010, 8'h12 + 8'(b)});
         end
      end
      @(negedge clk);
      bus.req = 4'b0000;
      #1;
      checks++;
      if ({busy, grant} !== 5'h0) begin
         errors++;
         $display("FAIL bp_release: got %h expected %h", {busy, grant}, 5'h0);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      set_data(0, 8'h07);
      bus.req = 4'b1000;
      bus.last_in = 4'b0000;
      bus.out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         set_data(3, 8'h30 + 8'(b));
         #1;
         checks++;
         if ({busy, sel, grant, bus.ack, bus.out_data} !==
             {1'b1, 2'd3, 4'b1000, 4'b1000, 8'h30 + 8'(b)}) begin
            errors++;
            $display("FAIL timeout_beat[%0d]: got %h expected %h", b,
                     {busy, sel, grant, bus.ack, bus.out_data},
                     {1'b1, 2'd3, 4'b1000, 4'b1000, 8'h30 + 8'(b)});
         end
      end
      @(negedge clk);
      bus.req = 4'b1001;
      #1;
      checks++;
      if ({busy, grant, sel, bus.out_valid} !== {1'b0, 4'b0000, 2'd3, 1'b0}) begin
         errors++;
         $display("FAIL timeout_release: got %h expected %h", {busy, grant, sel, bus.out_valid},
                  {1'b0, 4'b0000, 2'd3, 1'b0});
      end
      @(negedge clk);
      bus.req = 4'b0000;
      #1;
      checks++;
      if ({busy, grant, sel} !== {1'b1, 4'b0001, 2'd0}) begin
         errors++;
         $display("FAIL timeout_ptr_wrap: got %h expected %h", {busy, grant, sel},
                  {1'b1, 4'b0001, 2'd0});
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      bus.req = 4'b0010;
      bus.last_in = 4'b0010;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.req = 4'b0110;
      #1;
      checks++;
      if ({sel, bus.out_valid, bus.out_last} !== {2'd1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL rmid_single_beat: got %h expected %h", {sel, bus.out_valid, bus.out_last},
                  {2'd1, 1'b1, 1'b1});
      end
      @(negedge clk);
      bus.req = 4'b0100;
      bus.last_in = 4'b0000;
      @(negedge clk);
      #1;
      checks++;
      if ({busy, sel} !== {1'b1, 2'd2}) begin
         errors++;
         $display("FAIL rmid_owner: got %h expected %h", {busy, sel}, {1'b1, 2'd2});
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, sel, busy, bus.out_valid, bus.out_last, bus.ack} !== 13'h0) begin
         errors++;
         $display("FAIL rmid_async_clear: got %h expected %h",
                  {grant, sel, busy, bus.out_valid, bus.out_last, bus.ack}, 13'h0);
      end
      bus.req = 4'b1111;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({grant, sel} !== {4'b0001, 2'd0}) begin
         errors++;
         $display("FAIL rmid_restart_ptr: got %h expected %h", {grant, sel}, {4'b0001, 2'd0});
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.req = '0;
      bus.data_in = '0;
      bus.last_in = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_rotation();
      test_packet_lock();
      test_backpressure();
      test_timeout();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
